// File: rtl/bath_pkg.sv
// Shared types and constants for the bath heater controller.
// Optional cooldown stage is enabled by defining HEAT_COOLDOWN_EN.
package bath_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_IDLE    = 3'd1,
    ST_VENT    = 3'd2,
    ST_HEAT_LO = 3'd3,
    ST_HEAT_HI = 3'd4,
    ST_COOL    = 3'd5
  } bath_state_t;

  localparam int unsigned KEY_PWR   = 0;
  localparam int unsigned KEY_HEAT  = 1;
  localparam int unsigned KEY_FAN   = 2;
  localparam int unsigned KEY_LIGHT = 3;
  localparam int unsigned KEY_TIMER = 4;

  localparam logic [5:0] TIMER_STEP_DEFAULT = 6'd10;
  localparam logic [5:0] TIMER_MAX_DEFAULT  = 6'd60;

endpackage

// File: rtl/bath_min_timer.sv
// Auto-off minute timer: prescaler, minutes register, add/cancel/decrement.
// expire is a combinational one-cycle pulse on the terminal tick of the last minute.
module bath_min_timer
  import bath_pkg::*;
#(
  parameter logic [31:0] MIN_CYCLES = 32'd3_000_000_000,
  parameter logic [5:0]  TIMER_STEP = TIMER_STEP_DEFAULT,
  parameter logic [5:0]  TIMER_MAX  = TIMER_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       add,
  input  logic       clear,
  output logic [5:0] timer_min,
  output logic       expire
);

  logic [31:0] presc;
  logic [6:0]  sum;
  logic        active;
  logic        tick;

  always_comb begin
    sum    = {1'b0, timer_min} + {1'b0, TIMER_STEP};
    active = run && (timer_min != '0);
    tick   = active && (presc == MIN_CYCLES - 32'd1);
    expire = tick && (timer_min == 6'd1);
  end

  // clear (entering OFF) beats add, add beats a coincident tick
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      presc     <= '0;
      timer_min <= '0;
    end else if (add) begin
      presc     <= '0;
      timer_min <= (sum > {1'b0, TIMER_MAX}) ? '0 : sum[5:0];
    end else if (tick) begin
      presc     <= '0;
      timer_min <= timer_min - 6'd1;
    end else if (active) begin
      presc     <= presc + 32'd1;
    end
  end

endmodule

// File: rtl/bath_heater_ctrl.sv
// Bath heater mode FSM: power, two heat levels, vent, light and auto-off timer.
// Define HEAT_COOLDOWN_EN to include the fan run-on COOL state.
module bath_heater_ctrl
  import bath_pkg::*;
#(
  parameter logic [31:0] MIN_CYCLES  = 32'd3_000_000_000,
  parameter logic [31:0] COOL_CYCLES = 32'd1_500_000_000,
  parameter logic [5:0]  TIMER_STEP  = TIMER_STEP_DEFAULT,
  parameter logic [5:0]  TIMER_MAX   = TIMER_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] key_pulse,
  output logic       heat_lo,
  output logic       heat_hi,
  output logic       fan_on,
  output logic       light_on,
  output logic [5:0] timer_min,
  output logic [2:0] state
);

  bath_state_t state_q, state_d;
  logic        light_q, light_d;
  logic        timer_add, timer_expire, timer_run, enter_off;
  logic        pwr_cmd, to_cool, cool_pend;

`ifdef HEAT_COOLDOWN_EN
  logic        off_pend_q, off_pend_d;
  logic [31:0] cool_cnt;
  logic        cool_done;

  assign cool_done = (state_q == ST_COOL) && (cool_cnt == COOL_CYCLES - 32'd1);
`else
  logic unused_cool_cfg;
  assign unused_cool_cfg = ^COOL_CYCLES;
`endif

  assign timer_run = (state_q != ST_OFF);
  assign enter_off = (state_d == ST_OFF);

  always_comb begin
    state_d   = state_q;
    light_d   = light_q;
    timer_add = 1'b0;
    to_cool   = 1'b0;
    cool_pend = 1'b0;
`ifdef HEAT_COOLDOWN_EN
    off_pend_d = off_pend_q;
`endif
    // timer expiry acts as a power press and outranks any real key
    pwr_cmd = key_pulse[KEY_PWR] || timer_expire;

    if (pwr_cmd) begin
      case (state_q)
        ST_OFF:                 state_d = ST_IDLE;
        ST_IDLE, ST_VENT:       state_d = ST_OFF;
        ST_HEAT_LO, ST_HEAT_HI: begin
          to_cool   = 1'b1;
          cool_pend = 1'b1;
        end
        default: ;
      endcase
    end else if (key_pulse[KEY_HEAT]) begin
      case (state_q)
        ST_IDLE, ST_VENT: state_d = ST_HEAT_LO;
        ST_HEAT_LO:       state_d = ST_HEAT_HI;
        ST_HEAT_HI:       to_cool = 1'b1;
        ST_COOL: begin
          state_d = ST_HEAT_LO;
`ifdef HEAT_COOLDOWN_EN
          off_pend_d = 1'b0;
`endif
        end
        default: ;
      endcase
    end else if (key_pulse[KEY_FAN]) begin
      case (state_q)
        ST_IDLE: state_d = ST_VENT;
        ST_VENT: state_d = ST_IDLE;
        default: ;
      endcase
    end else if (key_pulse[KEY_TIMER]) begin
      timer_add = (state_q != ST_OFF);
    end

    if (to_cool) begin
`ifdef HEAT_COOLDOWN_EN
      state_d    = ST_COOL;
      off_pend_d = cool_pend;
`else
      state_d = cool_pend ? ST_OFF : ST_IDLE;
`endif
    end

`ifdef HEAT_COOLDOWN_EN
    // cooldown expiry only applies when this cycle's command left COOL in place
    if (cool_done && (state_d == ST_COOL)) begin
      state_d = off_pend_q ? ST_OFF : ST_IDLE;
    end
`endif

    if (key_pulse[KEY_LIGHT] && (state_q != ST_OFF)) light_d = !light_q;
    if (state_d == ST_OFF) light_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      light_q <= 1'b0;
      heat_lo <= 1'b0;
      heat_hi <= 1'b0;
      fan_on  <= 1'b0;
    end else begin
      state_q <= state_d;
      light_q <= light_d;
      heat_lo <= (state_d == ST_HEAT_LO);
      heat_hi <= (state_d == ST_HEAT_HI);
      fan_on  <= (state_d inside {ST_VENT, ST_HEAT_LO, ST_HEAT_HI, ST_COOL});
    end
  end

`ifdef HEAT_COOLDOWN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      off_pend_q <= 1'b0;
      cool_cnt   <= '0;
    end else begin
      off_pend_q <= off_pend_d;
      if ((state_q == ST_COOL) && (state_d == ST_COOL)) cool_cnt <= cool_cnt + 32'd1;
      else                                              cool_cnt <= '0;
    end
  end
`endif

  bath_min_timer #(
    .MIN_CYCLES (MIN_CYCLES),
    .TIMER_STEP (TIMER_STEP),
    .TIMER_MAX  (TIMER_MAX)
  ) u_min_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (timer_run),
    .add       (timer_add),
    .clear     (enter_off),
    .timer_min (timer_min),
    .expire    (timer_expire)
  );

  assign light_on = light_q;
  assign state    = state_q;

endmodule

// File: tb/tb_bath_heater_ctrl.sv
// Self-checking bench for bath_heater_ctrl: vector table, directed corner sequences
// and randomized keys against a deadline-based reference model.
module tb_bath_heater_ctrl;

  localparam int MIN_C  = 100;
  localparam int COOL_C = 50;
  localparam int TSTEP  = 10;
  localparam int TMAX   = 60;
`ifdef HEAT_COOLDOWN_EN
  localparam bit COOL_EN = 1'b1;
`else
  localparam bit COOL_EN = 1'b0;
`endif

  localparam logic [4:0] K_PWR = 5'b00001;
  localparam logic [4:0] K_HT  = 5'b00010;
  localparam logic [4:0] K_FAN = 5'b00100;
  localparam logic [4:0] K_LT  = 5'b01000;
  localparam logic [4:0] K_TMR = 5'b10000;

  localparam int S_OFF = 0, S_IDLE = 1, S_VENT = 2, S_HLO = 3, S_HHI = 4, S_COOL = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] key_pulse = '0;
  logic       heat_lo, heat_hi, fan_on, light_on;
  logic [5:0] timer_min;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: absolute-cycle deadlines instead of counters
  int m_cycle = 0;
  int m_state = S_OFF;
  bit m_light = 1'b0;
  int m_timer = 0;
  int m_next_tick = -1;
  int m_cool_end = -1;
  bit m_offp = 1'b0;

  always #5 clk = ~clk;

  bath_heater_ctrl #(
    .MIN_CYCLES  (32'd100),
    .COOL_CYCLES (32'd50),
    .TIMER_STEP  (6'd10),
    .TIMER_MAX   (6'd60)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_pulse (key_pulse),
    .heat_lo   (heat_lo),
    .heat_hi   (heat_hi),
    .fan_on    (fan_on),
    .light_on  (light_on),
    .timer_min (timer_min),
    .state     (state)
  );

  function automatic logic [12:0] pack(int st, bit hl, bit hh, bit fan, bit lt, int tm);
    return {st[2:0], hl, hh, fan, lt, tm[5:0]};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {state, heat_lo, heat_hi, fan_on, light_on, timer_min};
  endfunction

  function automatic logic [12:0] model_vec();
    return pack(m_state, m_state == S_HLO, m_state == S_HHI,
                (m_state >= S_VENT) && (m_state <= S_COOL), m_light, m_timer);
  endfunction

  task automatic model_step(input logic [4:0] k, input bit r);
    int n, ns, pend;
    bit tick, expire, timer_act;
    n = m_cycle;
    m_cycle++;
    if (r) begin
      m_state = S_OFF; m_light = 1'b0; m_timer = 0; m_offp = 1'b0;
      return;
    end
    ns = m_state; pend = -1; timer_act = 1'b0;
    tick   = (m_state != S_OFF) && (m_timer != 0) && (n == m_next_tick);
    expire = tick && (m_timer == 1);
    if (k[0] || expire) begin
      if (m_state == S_OFF) ns = S_IDLE;
      else if (m_state == S_IDLE || m_state == S_VENT) ns = S_OFF;
      else if (m_state == S_HLO || m_state == S_HHI) pend = 1;
    end else if (k[1]) begin
      if (m_state == S_IDLE || m_state == S_VENT || m_state == S_COOL) ns = S_HLO;
      else if (m_state == S_HLO) ns = S_HHI;
      else if (m_state == S_HHI) pend = 0;
    end else if (k[2]) begin
      if (m_state == S_IDLE) ns = S_VENT;
      else if (m_state == S_VENT) ns = S_IDLE;
    end else if (k[4]) begin
      timer_act = (m_state != S_OFF);
    end
    if (pend >= 0) begin
      if (COOL_EN) begin
        ns = S_COOL; m_offp = (pend == 1); m_cool_end = n + COOL_C;
      end else begin
        ns = (pend == 1) ? S_OFF : S_IDLE;
      end
    end
    if (m_state == S_COOL && ns == S_COOL && n == m_cool_end) ns = m_offp ? S_OFF : S_IDLE;
    if (k[3] && m_state != S_OFF) m_light = !m_light;
    if (ns == S_OFF) begin
      m_timer = 0; m_light = 1'b0;
    end else if (timer_act) begin
      m_timer += TSTEP;
      if (m_timer > TMAX) m_timer = 0;
      m_next_tick = n + MIN_C;
    end else if (tick) begin
      m_timer--;
      m_next_tick = n + MIN_C;
    end
    m_state = ns;
  endtask

  task automatic cyc(input logic [4:0] k, input bit r);
    logic [12:0] got, exp_v;
    @(negedge clk);
    key_pulse = k;
    rst = r;
    @(posedge clk);
    #1;
    key_pulse = '0;
    rst = 1'b0;
    model_step(k, r);
    got = dut_vec();
    exp_v = model_vec();
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL model cycle %0d keys=%b rst=%0d: got {st,lo,hi,fan,lt,tmin}=%h expected %h",
               m_cycle, k, r, got, exp_v);
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) cyc('0, 1'b0);
  endtask

  task automatic check(input string name, input int got, input int exp_v);
    n_tests++;
    if (got != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
    end
  endtask

  typedef struct {
    bit         r;
    logic [4:0] keys;
    int         st;
    bit         hl, hh, fan, lt;
    int         tm;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 5'b00000,        S_OFF,  0, 0, 0, 0, 0};
    tbl[1]  = '{1'b0, K_PWR,           S_IDLE, 0, 0, 0, 0, 0};
    tbl[2]  = '{1'b0, K_LT | K_FAN,    S_VENT, 0, 0, 1, 1, 0};
    tbl[3]  = '{1'b0, K_FAN,           S_IDLE, 0, 0, 0, 1, 0};
    tbl[4]  = '{1'b0, K_PWR|K_HT|K_FAN, S_OFF, 0, 0, 0, 0, 0};
    tbl[5]  = '{1'b0, K_HT,            S_OFF,  0, 0, 0, 0, 0};
    tbl[6]  = '{1'b0, K_LT,            S_OFF,  0, 0, 0, 0, 0};
    tbl[7]  = '{1'b0, K_TMR,           S_OFF,  0, 0, 0, 0, 0};
    tbl[8]  = '{1'b0, K_PWR,           S_IDLE, 0, 0, 0, 0, 0};
    tbl[9]  = '{1'b0, K_HT,            S_HLO,  1, 0, 1, 0, 0};
    tbl[10] = '{1'b0, K_HT,            S_HHI,  0, 1, 1, 0, 0};
    tbl[11] = '{1'b0, K_FAN,           S_HHI,  0, 1, 1, 0, 0};
    tbl[12] = '{1'b0, K_TMR,           S_HHI,  0, 1, 1, 0, 10};
    tbl[13] = '{1'b0, K_LT,            S_HHI,  0, 1, 1, 1, 10};
    tbl[14] = '{1'b1, K_HT,            S_OFF,  0, 0, 0, 0, 0};

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].keys, tbl[i].r);
      check($sformatf("table[%0d]", i), int'(dut_vec()),
            int'(pack(tbl[i].st, tbl[i].hl, tbl[i].hh, tbl[i].fan, tbl[i].lt, tbl[i].tm)));
    end

    // timer add / cancel / countdown, expiry outranks a coincident heat key
    cyc('0, 1'b1);
    cyc(K_PWR, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      cyc(K_TMR, 1'b0);
      check($sformatf("timer_press%0d", i), int'(timer_min), (i < 7) ? i * TSTEP : 0);
    end
    cyc(K_TMR, 1'b0);
    check("timer_restart", int'(timer_min), 10);
    idle(99);
    check("timer_before_dec", int'(timer_min), 10);
    idle(1);
    check("timer_first_dec", int'(timer_min), 9);
    idle(899);
    check("timer_last_min", int'(timer_min), 1);
    check("timer_last_state", int'(state), S_IDLE);
    cyc(K_HT, 1'b0);
    check("expire_state", int'(state), S_OFF);
    check("expire_timer", int'(timer_min), 0);

`ifdef HEAT_COOLDOWN_EN
    cyc('0, 1'b1);
    cyc(K_PWR, 1'b0);
    cyc(K_HT, 1'b0);
    cyc(K_HT, 1'b0);
    check("hh_vec", int'(dut_vec()), int'(pack(S_HHI, 0, 1, 1, 0, 0)));
    cyc(K_LT, 1'b0);
    cyc(K_PWR, 1'b0);
    check("cool_entry", int'(dut_vec()), int'(pack(S_COOL, 0, 0, 1, 1, 0)));
    idle(COOL_C - 1);
    check("cool_hold", int'(state), S_COOL);
    idle(1);
    check("cool_exit_off", int'(dut_vec()), int'(pack(S_OFF, 0, 0, 0, 0, 0)));

    cyc(K_PWR, 1'b0);
    cyc(K_HT, 1'b0);
    cyc(K_HT, 1'b0);
    cyc(K_HT, 1'b0);
    check("cool_from_heat", int'(state), S_COOL);
    idle(20);
    cyc(K_HT, 1'b0);
    check("cool_reheat", int'(state), S_HLO);
    idle(200);
    check("reheat_stays", int'(state), S_HLO);

    cyc('0, 1'b1);
    cyc(K_PWR, 1'b0);
    cyc(K_LT, 1'b0);
    for (int i = 0; i < 3; i++) cyc(K_TMR, 1'b0);
    cyc(K_HT, 1'b0);
    cyc(K_HT, 1'b0);
    cyc(K_PWR, 1'b0);
    check("pre_rst_cool", int'(dut_vec()), int'(pack(S_COOL, 0, 0, 1, 1, 30)));
    idle(10);
    cyc('0, 1'b1);
    check("rst_mid_cool", int'(dut_vec()), 0);
`else
    cyc('0, 1'b1);
    cyc(K_PWR, 1'b0);
    cyc(K_HT, 1'b0);
    cyc(K_HT, 1'b0);
    cyc(K_PWR, 1'b0);
    check("hh_power_off", int'(dut_vec()), int'(pack(S_OFF, 0, 0, 0, 0, 0)));
    cyc(K_PWR, 1'b0);
    cyc(K_HT, 1'b0);
    cyc(K_HT, 1'b0);
    cyc(K_HT, 1'b0);
    check("hh_heat_idle", int'(dut_vec()), int'(pack(S_IDLE, 0, 0, 0, 0, 0)));
    cyc(K_LT, 1'b0);
    cyc(K_TMR, 1'b0);
    cyc('0, 1'b1);
    check("rst_mid_op", int'(dut_vec()), 0);
`endif

    // randomized keys: mostly single presses, some multi-key cycles, rare resets
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] k;
      bit r;
      k = '0;
      r = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 3) == 0) k = 5'($urandom);
        else                           k = 5'(1 << $urandom_range(0, 4));
      end
      cyc(k, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bath_heater_ctrl.md
# bath_heater_ctrl

Mode controller for the bath heater, directly downstream of the key debouncer. It consumes the debouncer's 5-bit one-cycle key pulses and runs the appliance state machine (power, two heat levels, ventilation, light, auto-off timer). It drives registered enables for the heater relays, fan and lamp, plus the remaining-time value for the display block.

## Interface
- MIN_CYCLES, default 32'd3_000_000_000: clock cycles per timer minute (50 MHz system clock).
- COOL_CYCLES, default 32'd1_500_000_000: fan run-on length after heating stops (30 s).
- TIMER_STEP, default 6'd10: minutes added per timer key press.
- TIMER_MAX, default 6'd60: timer ceiling.
- clk  in  1  system clock, single domain.
- rst  in  1  synchronous, active-high reset.
- key_pulse  in  5  one-cycle debounced press pulses: [0] power, [1] heat, [2] fan, [3] light, [4] timer.
- heat_lo  out  1  low-heat relay enable.
- heat_hi  out  1  high-heat relay enable; heat_lo and heat_hi are never both 1.
- fan_on  out  1  fan relay enable.
- light_on  out  1  lamp enable.
- timer_min  out  6  minutes remaining, 0 means timer inactive.
- state  out  3  current state code, for the display.

## Operation
- States: OFF=0, IDLE=1, VENT=2, HEAT_LO=3, HEAT_HI=4, COOL=5.
- Outputs are decoded from state:
  - heat_lo is 1 only in HEAT_LO.
  - heat_hi is 1 only in HEAT_HI.
  - fan_on is 1 in VENT, HEAT_LO, HEAT_HI and COOL.
- Command priority: power > heat > fan > timer. Only the highest-priority command present in a cycle is acted on. Light is evaluated independently in the same cycle.
- Power key:
  - OFF → IDLE.
  - IDLE or VENT → OFF.
  - HEAT_LO or HEAT_HI → COOL, with off_pending=1.
  - COOL: ignored.
- Heat key:
  - IDLE or VENT → HEAT_LO.
  - HEAT_LO → HEAT_HI.
  - HEAT_HI → COOL, with off_pending=0.
  - COOL → HEAT_LO, clearing off_pending and the cooldown counter.
  - OFF: ignored.
- Fan key: IDLE↔VENT toggle. Ignored in all other states.
- Light key: toggles light_on in any state except OFF.
- Timer key, ignored in OFF:
  - timer_min ← timer_min+TIMER_STEP.
  - If the result would exceed TIMER_MAX, timer_min ← 0 (cancel).
  - The minute prescaler is cleared on every timer key press.
- Timer countdown:
  - While timer_min≠0 and state≠OFF, the prescaler counts 0..MIN_CYCLES-1.
  - On the terminal count, timer_min decrements.
  - When timer_min goes 1→0, a synthetic power-off is raised, handled exactly like the power key from a non-OFF state.
  - If a real key arrives in the same cycle, the synthetic power-off takes priority.
- COOL: the cooldown counter runs 0..COOL_CYCLES-1. On the terminal count, state → OFF if off_pending, else IDLE.
- Entering OFF by any path:
  - light_on=0, timer_min=0.
  - Prescaler and cooldown counter are cleared.
- Reset: state=OFF; all outputs 0; off_pending=0; both counters 0. A reset mid-operation (including mid-COOL) lands directly in OFF.

## Timing
- Key pulse in cycle n → state and outputs change at the clk edge ending cycle n, visible in n+1. One cycle of latency, all outputs registered.
- Timer decrement is visible the cycle after the prescaler reaches MIN_CYCLES-1.
- COOL exit occurs exactly COOL_CYCLES cycles after entry.
- A key pulse that is ignored produces no output change and does not disturb either counter.
- Counters are 32-bit unsigned and never wrap: each is cleared at its terminal count.

## Configuration
- HEAT_COOLDOWN_EN defined: behaviour as above.
- HEAT_COOLDOWN_EN undefined:
  - The COOL state and cooldown counter are compiled out.
  - Every transition into COOL goes directly to OFF (off_pending=1) or IDLE (off_pending=0) in the same cycle.
  - fan_on drops together with the heat enables.

## Structure
- Shared package bath_pkg holds:
  - the state enum;
  - key-bit index constants (KEY_PWR=0, KEY_HEAT=1, KEY_FAN=2, KEY_LIGHT=3, KEY_TIMER=4);
  - TIMER_STEP and TIMER_MAX defaults.
- One sub-module, bath_min_timer, contains the prescaler, the timer_min register and the add/cancel/decrement logic.
  - It outputs timer_min and a one-cycle expire pulse.
  - The parent FSM handles everything else.

## Test plan
Bench parameters: MIN_CYCLES=100, COOL_CYCLES=50, HEAT_COOLDOWN_EN defined.
- Power pulse, then heat, then heat → state 1,3,4. At HEAT_HI: heat_hi=1, heat_lo=0, fan_on=1, each one cycle after its pulse.
- From HEAT_HI, power pulse → state=5 with heat_hi=0, fan_on=1; exactly 50 cycles later → state=0, fan_on=0, light_on=0.
- From HEAT_LO, heat, heat → COOL; heat pressed 20 cycles into COOL → HEAT_LO. With no further keys, no OFF or IDLE transition occurs.
- Power on, then timer pressed 7 times → timer_min 10,20,…,60 then 0. Press once more (10) → decrements to 9 after 100 cycles → after 1000 cycles total, state=0.
- Power, heat and fan pulsed in the same cycle from IDLE → state=0 (power wins). Light and fan in the same cycle from IDLE → VENT with light_on=1.
- rst asserted mid-COOL with light_on=1 and timer_min=30 → next cycle all outputs 0, state=0. Repeat with HEAT_COOLDOWN_EN undefined: power from HEAT_HI → state=0 in one cycle.
